// File: rtl/dut_arb_pkg.sv
// Shared types and widths for the two-requester round-robin arbiter.
// Imported by the tag FIFO and the arbiter top.
package dut_arb_pkg;

    localparam int TAG_DEPTH_DEFAULT = 4;
    localparam int BYTE_W = 8;
    localparam int LANES  = 8;
    localparam int REQ_W  = BYTE_W * LANES;
    localparam int DOUT_W = 256;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

endpackage

// File: rtl/tag_fifo.sv
// One-bit tag FIFO recording which requester owns each in-flight issue.
// Push and pop may occur on the same edge, including when full.
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     din_i,
    input  logic                     pop_i,
    output logic                     head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != '0);
        // a full FIFO still accepts a push when the head leaves on the same edge
        do_push = push_i && ((count_q != DEPTH_C) || do_pop);
        if (do_push) begin
            mem_d[wr_q] = din_i;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/dut_rr_arbiter.sv
// Round-robin front end sharing one in-order engine between two requesters;
// results are steered back by a FIFO of issue tags.
module dut_rr_arbiter
    import dut_arb_pkg::*;
#(
    parameter int TAG_DEPTH = TAG_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_vld,
    output logic              req0_busy,
    input  logic [REQ_W-1:0]  req0_data,
    input  logic              req1_vld,
    output logic              req1_busy,
    input  logic [REQ_W-1:0]  req1_data,
    output logic              din_vld,
    input  logic              din_busy,
    output logic [BYTE_W-1:0] din_data_a,
    output logic [BYTE_W-1:0] din_data_b,
    output logic [BYTE_W-1:0] din_data_c,
    output logic [BYTE_W-1:0] din_data_d,
    output logic [BYTE_W-1:0] din_data_e,
    output logic [BYTE_W-1:0] din_data_f,
    output logic [BYTE_W-1:0] din_data_g,
    output logic [BYTE_W-1:0] din_data_h,
    input  logic              dout_vld,
    output logic              dout_busy,
    input  logic [DOUT_W-1:0] dout_data,
    output logic              rsp0_vld,
    input  logic              rsp0_busy,
    output logic              rsp1_vld,
    input  logic              rsp1_busy,
    output logic [DOUT_W-1:0] rsp_data
);

    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             tag_q, tag_d;
    logic [REQ_W-1:0] data_q, data_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, fifo_head;
    logic          push, pop;
    logic          win, grant;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tag_d   = tag_q;
        data_d  = data_q;
        push    = 1'b0;
        din_vld = 1'b0;
        // ptr_q names the requester that wins a tie
        win   = (req0_vld && req1_vld) ? ptr_q : req1_vld;
        grant = !rst && (state_q == IDLE) && (fifo_count < DEPTH_C)
                && (req0_vld || req1_vld);
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    tag_d   = win;
                    data_d  = win ? req1_data : req0_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                din_vld = 1'b1;
                if (!din_busy) begin
                    push    = !fifo_full;
                    ptr_d   = ~tag_q;
                    state_d = IDLE;
                end
            end
        endcase
        req0_busy = !(grant && !win);
        req1_busy = !(grant && win);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            tag_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign din_data_a = data_q[0*BYTE_W +: BYTE_W];
    assign din_data_b = data_q[1*BYTE_W +: BYTE_W];
    assign din_data_c = data_q[2*BYTE_W +: BYTE_W];
    assign din_data_d = data_q[3*BYTE_W +: BYTE_W];
    assign din_data_e = data_q[4*BYTE_W +: BYTE_W];
    assign din_data_f = data_q[5*BYTE_W +: BYTE_W];
    assign din_data_g = data_q[6*BYTE_W +: BYTE_W];
    assign din_data_h = data_q[7*BYTE_W +: BYTE_W];

    // results follow the oldest outstanding tag; nothing pops while empty
    assign rsp0_vld  = dout_vld && !fifo_empty && !fifo_head;
    assign rsp1_vld  = dout_vld && !fifo_empty && fifo_head;
    assign dout_busy = fifo_empty || (fifo_head ? rsp1_busy : rsp0_busy);
    assign pop       = dout_vld && !dout_busy;
    assign rsp_data  = dout_data;

    tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (tag_q),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_dut_rr_arbiter.sv
// Directed bench for dut_rr_arbiter: reset, single issue, contention,
// full FIFO, backpressure and reset in the middle of traffic.
module tb_dut_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_vld, req1_vld;
    logic         req0_busy, req1_busy;
    logic [63:0]  req0_data, req1_data;
    logic         din_vld, din_busy;
    logic [7:0]   din_data_a, din_data_b, din_data_c, din_data_d;
    logic [7:0]   din_data_e, din_data_f, din_data_g, din_data_h;
    logic         dout_vld, dout_busy;
    logic [255:0] dout_data, rsp_data;
    logic         rsp0_vld, rsp0_busy, rsp1_vld, rsp1_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dut_rr_arbiter #(.TAG_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_vld   (req0_vld),
        .req0_busy  (req0_busy),
        .req0_data  (req0_data),
        .req1_vld   (req1_vld),
        .req1_busy  (req1_busy),
        .req1_data  (req1_data),
        .din_vld    (din_vld),
        .din_busy   (din_busy),
        .din_data_a (din_data_a),
        .din_data_b (din_data_b),
        .din_data_c (din_data_c),
        .din_data_d (din_data_d),
        .din_data_e (din_data_e),
        .din_data_f (din_data_f),
        .din_data_g (din_data_g),
        .din_data_h (din_data_h),
        .dout_vld   (dout_vld),
        .dout_busy  (dout_busy),
        .dout_data  (dout_data),
        .rsp0_vld   (rsp0_vld),
        .rsp0_busy  (rsp0_busy),
        .rsp1_vld   (rsp1_vld),
        .rsp1_busy  (rsp1_busy),
        .rsp_data   (rsp_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_vld = 0; req1_vld = 0; din_busy = 0;
        dout_vld = 0; rsp0_busy = 0; rsp1_busy = 0;
        req0_data = '0; req1_data = '0; dout_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_vld = 1; req1_vld = 1; dout_vld = 1;
        din_busy = 0; rsp0_busy = 0; rsp1_busy = 0;
        req0_data = 64'h1111; req1_data = 64'h2222; dout_data = '1;
        #1;
        checks++; if (req0_busy !== 1'b1) begin errors++; $display("FAIL rst_req0_busy got %b exp 1", req0_busy); end
        checks++; if (req1_busy !== 1'b1) begin errors++; $display("FAIL rst_req1_busy got %b exp 1", req1_busy); end
        checks++; if (din_vld !== 1'b0) begin errors++; $display("FAIL rst_din_vld got %b exp 0", din_vld); end
        checks++; if ({din_data_a, din_data_h} !== 16'h0) begin errors++; $display("FAIL rst_din_data got %h%h exp 0", din_data_h, din_data_a); end
        checks++; if ({rsp0_vld, rsp1_vld} !== 2'b00) begin errors++; $display("FAIL rst_rsp_vld got %b%b exp 00", rsp0_vld, rsp1_vld); end
        checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", dut.u_fifo.count_o); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req0_vld = 1; req0_data = 64'h0807060504030201;
        #1;
        checks++; if ({req0_busy, req1_busy} !== 2'b01) begin errors++; $display("FAIL single_grant got %b%b exp 01", req0_busy, req1_busy); end
        checks++; if (din_vld !== 1'b0) begin errors++; $display("FAIL single_din_idle got %b exp 0", din_vld); end
        tick();
        req0_vld = 0;
        #1;
        checks++; if (din_vld !== 1'b1) begin errors++; $display("FAIL single_din_vld got %b exp 1", din_vld); end
        checks++; if (din_data_a !== 8'h01) begin errors++; $display("FAIL single_byte_a got %h exp 01", din_data_a); end
        checks++; if (din_data_h !== 8'h08) begin errors++; $display("FAIL single_byte_h got %h exp 08", din_data_h); end
        checks++; if (din_data_d !== 8'h04) begin errors++; $display("FAIL single_byte_d got %h exp 04", din_data_d); end
        tick();
        checks++; if (din_vld !== 1'b0) begin errors++; $display("FAIL single_din_drop got %b exp 0", din_vld); end
        checks++; if (dut.u_fifo.count_o !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", dut.u_fifo.count_o); end
        dout_vld = 1; dout_data = {32{8'hAB}};
        #1;
        checks++; if ({rsp0_vld, rsp1_vld} !== 2'b10) begin errors++; $display("FAIL single_rsp got %b%b exp 10", rsp0_vld, rsp1_vld); end
        checks++; if (rsp_data !== {32{8'hAB}}) begin errors++; $display("FAIL single_rsp_data got %h", rsp_data); end
        checks++; if (dout_busy !== 1'b0) begin errors++; $display("FAIL single_dout_busy got %b exp 0", dout_busy); end
        tick();
        dout_vld = 0;
        #1;
        checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL single_pop got %0d exp 0", dut.u_fifo.count_o); end
    endtask

    task automatic test_contention();
        logic w;
        do_reset();
        req0_vld = 1; req1_vld = 1;
        req0_data = 64'h00000000000000A0; req1_data = 64'h00000000000000B1;
        for (int i = 0; i < 4; i++) begin
            w = i[0];
            #1;
            checks++; if ({req0_busy, req1_busy} !== {w, ~w}) begin errors++; $display("FAIL cont_grant%0d got %b%b exp %b%b", i, req0_busy, req1_busy, w, ~w); end
            tick();
            checks++; if (din_data_a !== (w ? 8'hB1 : 8'hA0)) begin errors++; $display("FAIL cont_data%0d got %h", i, din_data_a); end
            checks++; if ({req0_busy, req1_busy} !== 2'b11) begin errors++; $display("FAIL cont_issue_busy%0d got %b%b exp 11", i, req0_busy, req1_busy); end
            tick();
        end
        req0_vld = 0; req1_vld = 0;
        checks++; if (dut.u_fifo.count_o !== 3'd4) begin errors++; $display("FAIL cont_count got %0d exp 4", dut.u_fifo.count_o); end
        dout_vld = 1;
        for (int k = 0; k < 4; k++) begin
            w = k[0];
            #1;
            checks++; if ({rsp0_vld, rsp1_vld} !== {~w, w}) begin errors++; $display("FAIL cont_rsp%0d got %b%b exp %b%b", k, rsp0_vld, rsp1_vld, ~w, w); end
            tick();
        end
        dout_vld = 0;
        checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL cont_drain got %0d exp 0", dut.u_fifo.count_o); end
    endtask

    task automatic test_full();
        do_reset();
        req0_vld = 1; req0_data = 64'h55;
        repeat (4) begin tick(); tick(); end
        req1_vld = 1; req1_data = 64'h66;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({req0_busy, req1_busy, din_vld} !== 3'b110) begin errors++; $display("FAIL full_block%0d got %b%b%b exp 110", i, req0_busy, req1_busy, din_vld); end
            tick();
        end
        checks++; if (dut.u_fifo.count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", dut.u_fifo.count_o); end
        dout_vld = 1;
        #1;
        checks++; if ({req0_busy, req1_busy, dout_busy} !== 3'b110) begin errors++; $display("FAIL full_pop_cycle got %b%b%b exp 110", req0_busy, req1_busy, dout_busy); end
        tick();
        dout_vld = 0;
        #1;
        checks++; if (dut.u_fifo.count_o !== 3'd3) begin errors++; $display("FAIL full_after_pop got %0d exp 3", dut.u_fifo.count_o); end
        checks++; if ({req0_busy, req1_busy} !== 2'b10) begin errors++; $display("FAIL full_regrant got %b%b exp 10", req0_busy, req1_busy); end
        tick();
        req0_vld = 0; req1_vld = 0; dout_vld = 1;
        #1;
        checks++; if ({din_vld, din_data_a} !== {1'b1, 8'h66}) begin errors++; $display("FAIL full_issue got %b %h exp 1 66", din_vld, din_data_a); end
        tick();
        dout_vld = 0;
        #1;
        checks++; if (dut.u_fifo.count_o !== 3'd3) begin errors++; $display("FAIL push_pop_same got %0d exp 3", dut.u_fifo.count_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req1_vld = 1; req1_data = 64'h8877665544332211;
        tick();
        req1_vld = 0; din_busy = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({din_vld, din_data_a, din_data_h} !== {1'b1, 8'h11, 8'h88}) begin errors++; $display("FAIL bp_hold%0d got %b %h %h", i, din_vld, din_data_a, din_data_h); end
            checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL bp_count%0d got %0d exp 0", i, dut.u_fifo.count_o); end
            tick();
        end
        din_busy = 0;
        tick();
        dout_vld = 1; rsp1_busy = 1;
        #1;
        checks++; if ({rsp0_vld, rsp1_vld, dout_busy} !== 3'b011) begin errors++; $display("FAIL bp_rsp1_busy got %b%b%b exp 011", rsp0_vld, rsp1_vld, dout_busy); end
        tick();
        checks++; if (dut.u_fifo.count_o !== 3'd1) begin errors++; $display("FAIL bp_no_pop got %0d exp 1", dut.u_fifo.count_o); end
        rsp1_busy = 0;
        #1;
        checks++; if (dout_busy !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", dout_busy); end
        tick();
        #1;
        checks++; if ({dout_busy, rsp0_vld, rsp1_vld} !== 3'b100) begin errors++; $display("FAIL bp_empty_stall got %b%b%b exp 100", dout_busy, rsp0_vld, rsp1_vld); end
        tick();
        checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL bp_no_underflow got %0d exp 0", dut.u_fifo.count_o); end
        dout_vld = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_vld = 1; req0_data = 64'h77;
        repeat (3) begin tick(); tick(); end
        tick();
        req0_vld = 0; din_busy = 1; dout_vld = 1;
        #1;
        checks++; if ({din_vld, rsp0_vld} !== 2'b11) begin errors++; $display("FAIL mid_pre got %b%b exp 11", din_vld, rsp0_vld); end
        checks++; if (dut.u_fifo.count_o !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d exp 3", dut.u_fifo.count_o); end
        rst = 1;
        #1;
        checks++; if ({din_vld, rsp0_vld, rsp1_vld} !== 3'b000) begin errors++; $display("FAIL mid_async got %b%b%b exp 000", din_vld, rsp0_vld, rsp1_vld); end
        checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", dut.u_fifo.count_o); end
        tick();
        rst = 0; din_busy = 0; dout_vld = 0;
        tick();
        checks++; if ({din_vld, dut.u_fifo.count_o} !== 4'b0000) begin errors++; $display("FAIL mid_after got %b %0d exp 0 0", din_vld, dut.u_fifo.count_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dut_rr_arbiter.md
DUT_RR_ARBITER -- requirements
Module: dut_rr_arbiter

Interface
REQ-001 Parameters SHALL be:
- TAG_DEPTH, default 4: maximum outstanding transactions inside dut; power of two, at least 2.

REQ-002 Ports SHALL be as follows, listed as name, direction, width, meaning:
- clk, in, 1: the only clock; all state changes on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req0_vld, in, 1: requester 0 has a transaction.
- req0_busy, out, 1: requester 0 transfer refused.
- req0_data, in, 64: eight bytes; a in [7:0] through h in [63:56].
- req1_vld, in, 1: requester 1 has a transaction.
- req1_busy, out, 1: requester 1 transfer refused.
- req1_data, in, 64: same packing as req0_data.
- din_vld, out, 1: issue to dut.
- din_busy, in, 1: dut refuses issue.
- din_data_a .. din_data_h, out, 8 each: issued bytes a..h.
- dout_vld, in, 1: dut result valid.
- dout_busy, out, 1: result refused.
- dout_data, in, 256: dut result.
- rsp0_vld, out, 1: result for requester 0.
- rsp0_busy, in, 1: requester 0 refuses result.
- rsp1_vld, out, 1: result for requester 1.
- rsp1_busy, in, 1: requester 1 refuses result.
- rsp_data, out, 256: shared result bus, equal to dout_data.

REQ-003 Every channel SHALL transfer on a rising edge where vld=1 and busy=0.

Function
REQ-004 The issue FSM SHALL have two states: IDLE and ISSUE.

REQ-005 In IDLE, if any reqN_vld=1 and count<TAG_DEPTH, the block SHALL:
- grant one requester by round-robin;
- drive that requester's busy low in the same cycle;
- register its data into din_data_a..h;
- register the winner tag;
- go to ISSUE.

REQ-006 The round-robin pointer SHALL give priority to the requester not most recently issued; with both valid, grants SHALL alternate 0,1,0,1.

REQ-007 reqN_busy SHALL be 1 whenever state=ISSUE, count=TAG_DEPTH, or N is not the winner.

REQ-008 In ISSUE, din_vld SHALL be 1 and din_data SHALL stay stable until din_busy=0. On that edge the block SHALL push the tag into the tag FIFO, update the pointer, and return to IDLE.

REQ-009 Issue throughput SHALL be at most one transaction per 2 cycles. Latency from req accept to din_vld SHALL be 1 cycle.

REQ-010 count SHALL equal the tag FIFO occupancy, in the range 0..TAG_DEPTH.

REQ-011 Results SHALL be routed by the FIFO head tag, combinationally:
- rspN_vld = dout_vld AND FIFO not empty AND head=N;
- dout_busy = FIFO empty OR busy of the head requester.

REQ-012 On a dout transfer the block SHALL pop the tag FIFO.

REQ-013 A push and a pop on the same edge SHALL leave count unchanged, including when count=TAG_DEPTH.

REQ-014 With count=TAG_DEPTH, no new grant SHALL occur until a pop. An issue already in ISSUE is never blocked, because it was admitted with count<TAG_DEPTH.

REQ-015 dout_vld while the FIFO is empty SHALL be stalled (dout_busy=1) and never dropped.

REQ-016 Results SHALL return in issue order; the dut is in-order.

Reset
REQ-017 While rst=1, and immediately on assertion, the block SHALL set:
- state IDLE;
- pointer favouring req0;
- tag FIFO empty (count 0);
- din_vld 0 and din_data_a..h all 0;
- req0_busy and req1_busy 1 combinationally from the held state;
- rsp0_vld and rsp1_vld 0.

REQ-018 Reset mid-operation SHALL discard every outstanding tag and the pending issue. The dut SHALL share the same rst.

Structure
REQ-019 Package dut_arb_pkg SHALL hold:
- TAG_DEPTH default;
- BYTE_W=8, LANES=8, DOUT_W=256;
- the state enum {IDLE, ISSUE}.

REQ-020 Sub-module tag_fifo SHALL be a 1-bit-wide FIFO of depth TAG_DEPTH with count, full and empty outputs. It is the only sub-module.

Verification
REQ-021 Single request: req0_data=0x0807060504030201 with din_busy=0 SHALL give din_vld=1 one cycle later with din_data_a=0x01 and din_data_h=0x08. A later dout_vld with 0xAB.. SHALL appear on rsp0 only.

REQ-022 Contention: with req0 and req1 both held valid for 4 issues, grants SHALL be 0,1,0,1. Results returned in order SHALL go to rsp0, rsp1, rsp0, rsp1.

REQ-023 Full: with dout_vld=0, after 4 issues req0 and req1 SHALL stay busy. A single dout transfer SHALL re-enable a grant on the next IDLE cycle.

REQ-024 Backpressure:
- din_busy=1 for 5 cycles SHALL hold din_data stable and count unchanged.
- rsp1_busy=1 with head=1 SHALL force dout_busy=1 and no pop.

REQ-025 Reset mid-operation: rst asserted with count=3 and state ISSUE SHALL give, within the same cycle:
- din_vld=0 and rsp0_vld=rsp1_vld=0;
- count=0 after release.
